complex_dot_product_row_scheduler: RTL and testbench

Sequencing controller for the complex 8-unit dot-product multiply engine. It runs a matrix-vector job of `no_of_rows` rows, each `no_of_multiples` packages long. For every package it generates matrix-row and vector memory read addresses and drives the engine's per-row reset, clear and read-now strobes. It captures each row's dot product and returns the results in row order over a valid/ready port. It sits between the job-issuing control logic and one shared `complex_eight_Dot_Product_Multiply_with_control_row` instance.

---
 rtl/complex_dot_product_row_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_complex_dot_product_row_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_dot_product_row_scheduler.sv
// complex_dot_product_row_scheduler
//
// Sequences a matrix-vector job over one shared complex 8-unit dot-product
// engine. For every row it clears and resets the engine, then issues
// no_of_multiples paired matrix/vector reads. A read-now strobe follows each
// read once the memory data has arrived. The rising edge of the engine's
// finish captures that row's result, which is returned in row order over a
// valid/ready port.
//
// Ports
//   clk, main_reset         clock, async active-high reset
//   start                   one-cycle job request (honoured only when idle)
//   no_of_rows              rows in the job
//   no_of_multiples         packages per row
//   matrix_base_addr        first matrix package address
//   vector_base_addr        first vector package address
//   busy, done              job in progress / one-cycle end pulse
//   mat_rd_en, mat_rd_addr  matrix memory read
//   vec_rd_en, vec_rd_addr  vector memory read
//   dp_clear                engine main_reset
//   dp_reset                engine reset
//   dp_read_now             engine outsider_read_now
//   dp_no_of_multiples      latched package count
//   dp_finish, dp_result    engine finish level and dot product
//   res_valid, res_ready    result handshake
//   res_data, res_row       captured result and its row index
//   timeout_err             sticky watchdog flag (DP_SCHED_TIMEOUT_EN only)
//
// Build option: define DP_SCHED_TIMEOUT_EN to add a WAIT_RESULT watchdog
// of TIMEOUT_CYCLES cycles that aborts the job and sets timeout_err.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | waiting for start
// SETUP       | engine clear, engine reset, then settle time
// ISSUE       | paired reads every ISSUE_GAP cycles, read-now tail
// WAIT_RESULT | waiting for a rising edge of dp_finish
// OUTPUT      | res_valid held until res_ready
// DONE        | done pulse, then back to IDLE

module complex_dot_product_row_scheduler #(
  parameter int ELEMENT_WIDTH  = 64,
  parameter int ADDR_WIDTH     = 13,
  parameter int ROW_WIDTH      = 16,
  parameter int MEM_LATENCY    = 1,
  parameter int ISSUE_GAP      = 2,
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     main_reset,
  input  logic                     start,
  input  logic [ROW_WIDTH-1:0]     no_of_rows,
  input  logic [31:0]              no_of_multiples,
  input  logic [ADDR_WIDTH-1:0]    matrix_base_addr,
  input  logic [ADDR_WIDTH-1:0]    vector_base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     mat_rd_en,
  output logic                     vec_rd_en,
  output logic [ADDR_WIDTH-1:0]    mat_rd_addr,
  output logic [ADDR_WIDTH-1:0]    vec_rd_addr,
  output logic                     dp_clear,
  output logic                     dp_reset,
  output logic                     dp_read_now,
  output logic [31:0]              dp_no_of_multiples,
  input  logic                     dp_finish,
  input  logic [ELEMENT_WIDTH-1:0] dp_result,
  output logic                     res_valid,
  output logic [ELEMENT_WIDTH-1:0] res_data,
  output logic [ROW_WIDTH-1:0]     res_row,
`ifdef DP_SCHED_TIMEOUT_EN
  output logic                     timeout_err,
`endif
  input  logic                     res_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [31:0] SETUP_LOAD = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] RESET_TC   = 32'(SETUP_CYCLES - 2);
  localparam logic [31:0] GAP_LOAD   = 32'(ISSUE_GAP - 1);
  localparam logic [31:0] LAT_LOAD   = 32'(MEM_LATENCY - 1);
  localparam logic [31:0] WDOG_LOAD  = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]             state;
  logic [ROW_WIDTH-1:0]   rows_lat;
  logic [ROW_WIDTH-1:0]   row;
  logic [31:0]            k;
  logic [31:0]            tmr;
  logic                   all_issued;
  logic                   empty_hold;
  logic                   finish_q;
  logic [ADDR_WIDTH-1:0]  mat_row_base;
  logic [ADDR_WIDTH-1:0]  vec_base;
  logic [MEM_LATENCY-1:0] rd_pipe;
  logic [MEM_LATENCY:0]   rd_chain;
  logic                   issue_now;
  logic                   last_pkg;
  logic                   last_row;
  logic                   finish_rise;

  // One shared down-counter: setup length, issue spacing, read-now tail
  // after the last read, and (optionally) the result watchdog.
  assign issue_now   = (state == S_ISSUE) && !all_issued && (tmr == '0);
  assign last_pkg    = (k == dp_no_of_multiples - 32'd1);
  assign last_row    = (row == rows_lat - ROW_WIDTH'(1));
  assign finish_rise = dp_finish && !finish_q;

  assign busy        = (state != S_IDLE);
  // An empty job sits one extra cycle in DONE so that its done pulse has
  // the same start-to-done spacing as the engine's setup handshake.
  assign done        = (state == S_DONE) && !empty_hold;
  assign dp_clear    = (state == S_SETUP) && (tmr == SETUP_LOAD);
  assign dp_reset    = (state == S_SETUP) && (tmr == RESET_TC);
  assign res_valid   = (state == S_OUTPUT);

  assign mat_rd_en   = issue_now;
  assign vec_rd_en   = issue_now;
  // The running row base already holds matrix_base + row*M (mod 2^ADDR_WIDTH).
  assign mat_rd_addr = issue_now ? mat_row_base + k[ADDR_WIDTH-1:0] : '0;
  assign vec_rd_addr = issue_now ? vec_base + k[ADDR_WIDTH-1:0] : '0;

  // Delay line that turns each read strobe into a read-now MEM_LATENCY later.
  assign rd_chain    = {rd_pipe, issue_now};
  assign dp_read_now = rd_pipe[MEM_LATENCY-1];

  always_ff @(posedge clk or posedge main_reset) begin
    if (main_reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= rd_chain[MEM_LATENCY-1:0];
    end
  end

  always_ff @(posedge clk or posedge main_reset) begin
    if (main_reset) begin
      state              <= S_IDLE;
      rows_lat           <= '0;
      row                <= '0;
      k                  <= '0;
      tmr                <= '0;
      all_issued         <= 1'b0;
      empty_hold         <= 1'b0;
      finish_q           <= 1'b0;
      mat_row_base       <= '0;
      vec_base           <= '0;
      dp_no_of_multiples <= '0;
      res_data           <= '0;
      res_row            <= '0;
`ifdef DP_SCHED_TIMEOUT_EN
      timeout_err        <= 1'b0;
`endif
    end else begin
      finish_q <= dp_finish;
      case (state)
        S_IDLE: begin
          if (start) begin
            rows_lat           <= no_of_rows;
            dp_no_of_multiples <= no_of_multiples;
            mat_row_base       <= matrix_base_addr;
            vec_base           <= vector_base_addr;
            row                <= '0;
`ifdef DP_SCHED_TIMEOUT_EN
            timeout_err        <= 1'b0;
`endif
            if ((no_of_rows == '0) || (no_of_multiples == '0)) begin
              empty_hold <= 1'b1;
              state      <= S_DONE;
            end else begin
              empty_hold <= 1'b0;
              tmr        <= SETUP_LOAD;
              state      <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          k          <= '0;
          all_issued <= 1'b0;
          if (tmr == '0) begin
            state <= S_ISSUE;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end

        S_ISSUE: begin
          if (issue_now) begin
            k <= k + 32'd1;
            if (last_pkg) begin
              all_issued <= 1'b1;
              tmr        <= LAT_LOAD;
            end else begin
              tmr <= GAP_LOAD;
            end
          end else if (tmr != '0) begin
            tmr <= tmr - 32'd1;
          end else if (all_issued) begin
            // Last read-now is on the engine this cycle.
            tmr   <= WDOG_LOAD;
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (finish_rise) begin
            res_data <= dp_result;
            res_row  <= row;
            state    <= S_OUTPUT;
          end
`ifdef DP_SCHED_TIMEOUT_EN
          else if (tmr == '0) begin
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end else begin
            tmr <= tmr - 32'd1;
          end
`endif
        end

        S_OUTPUT: begin
          if (res_ready) begin
            if (last_row) begin
              state <= S_DONE;
            end else begin
              row          <= row + ROW_WIDTH'(1);
              mat_row_base <= mat_row_base + dp_no_of_multiples[ADDR_WIDTH-1:0];
              tmr          <= SETUP_LOAD;
              state        <= S_SETUP;
            end
          end
        end

        S_DONE: begin
          if (empty_hold) begin
            empty_hold <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_dot_product_row_scheduler.sv
// Directed bench for complex_dot_product_row_scheduler. A negedge monitor
// logs strobes, addresses and handshakes with their cycle numbers; the main
// sequence drives jobs and compares the logs with hand-computed values.

module tb_complex_dot_product_row_scheduler;

  localparam int EW  = 64;
  localparam int AW  = 13;
  localparam int RW  = 16;
  localparam int LAT = 1;
  localparam int GAP = 2;
  localparam int SET = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          main_reset;
  logic          start;
  logic [RW-1:0] no_of_rows;
  logic [31:0]   no_of_multiples;
  logic [AW-1:0] matrix_base_addr;
  logic [AW-1:0] vector_base_addr;
  logic          busy;
  logic          done;
  logic          mat_rd_en;
  logic          vec_rd_en;
  logic [AW-1:0] mat_rd_addr;
  logic [AW-1:0] vec_rd_addr;
  logic          dp_clear;
  logic          dp_reset;
  logic          dp_read_now;
  logic [31:0]   dp_no_of_multiples;
  logic          dp_finish;
  logic [EW-1:0] dp_result;
  logic          res_valid;
  logic [EW-1:0] res_data;
  logic [RW-1:0] res_row;
  logic          res_ready;
`ifdef DP_SCHED_TIMEOUT_EN
  logic          timeout_err;
`endif

  complex_dot_product_row_scheduler #(
    .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .ROW_WIDTH(RW), .MEM_LATENCY(LAT),
    .ISSUE_GAP(GAP), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .main_reset(main_reset), .start(start),
    .no_of_rows(no_of_rows), .no_of_multiples(no_of_multiples),
    .matrix_base_addr(matrix_base_addr), .vector_base_addr(vector_base_addr),
    .busy(busy), .done(done),
    .mat_rd_en(mat_rd_en), .vec_rd_en(vec_rd_en),
    .mat_rd_addr(mat_rd_addr), .vec_rd_addr(vec_rd_addr),
    .dp_clear(dp_clear), .dp_reset(dp_reset), .dp_read_now(dp_read_now),
    .dp_no_of_multiples(dp_no_of_multiples),
    .dp_finish(dp_finish), .dp_result(dp_result),
    .res_valid(res_valid), .res_data(res_data), .res_row(res_row),
`ifdef DP_SCHED_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  int            rd_cyc[$];
  logic [1:0]    en_q[$];
  logic [AW-1:0] mat_q[$];
  logic [AW-1:0] vec_q[$];
  int            rn_cyc[$];
  int            clr_cyc[$];
  int            rst_cyc[$];
  int            done_cyc[$];
  int            hs_cyc[$];
  logic [EW-1:0] hs_data[$];
  logic [RW-1:0] hs_row[$];
  int            vrise_cyc[$];
  int            brise_cyc[$];
  int            bfall_cyc[$];
  int            fin_cyc[$];
  logic          busy_prev = 1'b0;
  logic          valid_prev = 1'b0;

  always @(negedge clk) begin
    if (mat_rd_en || vec_rd_en) begin
      rd_cyc.push_back(cyc);
      en_q.push_back({mat_rd_en, vec_rd_en});
      mat_q.push_back(mat_rd_addr);
      vec_q.push_back(vec_rd_addr);
    end
    if (dp_read_now) rn_cyc.push_back(cyc);
    if (dp_clear)    clr_cyc.push_back(cyc);
    if (dp_reset)    rst_cyc.push_back(cyc);
    if (done)        done_cyc.push_back(cyc);
    if (res_valid && res_ready) begin
      hs_cyc.push_back(cyc);
      hs_data.push_back(res_data);
      hs_row.push_back(res_row);
    end
    if (res_valid && !valid_prev) vrise_cyc.push_back(cyc);
    if (busy && !busy_prev)       brise_cyc.push_back(cyc);
    if (!busy && busy_prev)       bfall_cyc.push_back(cyc);
    busy_prev  = busy;
    valid_prev = res_valid;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); en_q.delete(); mat_q.delete(); vec_q.delete();
    rn_cyc.delete(); clr_cyc.delete(); rst_cyc.delete(); done_cyc.delete();
    hs_cyc.delete(); hs_data.delete(); hs_row.delete(); vrise_cyc.delete();
    brise_cyc.delete(); bfall_cyc.delete(); fin_cyc.delete();
  endtask

  task automatic start_job(input logic [RW-1:0] rows, input logic [31:0] m,
                           input logic [AW-1:0] mb, input logic [AW-1:0] vb,
                           output int t);
    no_of_rows       = rows;
    no_of_multiples  = m;
    matrix_base_addr = mb;
    vector_base_addr = vb;
    start            = 1'b1;
    t                = cyc + 1;
    tick();
    start            = 1'b0;
  endtask

  task automatic wait_rn(input int n);
    for (int i = 0; i < 200 && rn_cyc.size() < n; i++) tick();
    check_val("read_now_wait", 64'(rn_cyc.size() >= n), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) tick();
    check_val("idle_wait", 64'(busy), 64'd0);
    tick();
  endtask

  // Engine stand-in: raise finish once WAIT_RESULT is reached, optionally
  // stall the result port, and drop finish after the handshake.
  task automatic do_row(input int total_rn, input logic [EW-1:0] val, input int stall);
    wait_rn(total_rn);
    tick();
    dp_result = val;
    dp_finish = 1'b1;
    fin_cyc.push_back(cyc);
    res_ready = (stall == 0);
    for (int i = 0; i < 50 && !res_valid; i++) tick();
    check_val("valid_wait", 64'(res_valid), 64'd1);
    if (stall > 0) begin
      repeat (stall) tick();
      res_ready = 1'b1;
    end
    tick();
    dp_finish = 1'b0;
  endtask

  int t;
  logic [AW-1:0] exp_mat2 [6];

  initial begin
    main_reset = 1'b1;
    start = 1'b0; no_of_rows = '0; no_of_multiples = '0;
    matrix_base_addr = '0; vector_base_addr = '0;
    dp_finish = 1'b0; dp_result = '0; res_ready = 1'b1;
    repeat (3) tick();

    // reset state
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_strobes", 64'({done, mat_rd_en, vec_rd_en, dp_clear, dp_reset, dp_read_now, res_valid}), 64'd0);
    check_val("rst_res_data", res_data, 64'd0);
    check_val("rst_res_row", 64'(res_row), 64'd0);
    check_val("rst_dp_m", 64'(dp_no_of_multiples), 64'd0);
    main_reset = 1'b0;
    tick();

    // single row
    clear_logs();
    start_job(16'd1, 32'd3, 13'h010, 13'h020, t);
    do_row(3, 64'hABCD, 0);
    wait_idle();
    check_val("r1_busy_rise", 64'(brise_cyc[0]), 64'(t));
    check_val("r1_clr_n", 64'(clr_cyc.size()), 64'd1);
    check_val("r1_clr_cyc", 64'(clr_cyc[0]), 64'(t));
    check_val("r1_rst_cyc", 64'(rst_cyc[0]), 64'(t + 1));
    check_val("r1_rd_n", 64'(rd_cyc.size()), 64'd3);
    check_val("r1_rn_n", 64'(rn_cyc.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("r1_rd_cyc%0d", i), 64'(rd_cyc[i]), 64'(t + SET + GAP * i));
      check_val($sformatf("r1_en%0d", i), 64'(en_q[i]), 64'd3);
      check_val($sformatf("r1_mat%0d", i), 64'(mat_q[i]), 64'(13'h010 + i));
      check_val($sformatf("r1_vec%0d", i), 64'(vec_q[i]), 64'(13'h020 + i));
      check_val($sformatf("r1_rn_cyc%0d", i), 64'(rn_cyc[i]), 64'(t + SET + GAP * i + LAT));
    end
    check_val("r1_valid_rise", 64'(vrise_cyc[0]), 64'(fin_cyc[0] + 1));
    check_val("r1_res_data", hs_data[0], 64'hABCD);
    check_val("r1_res_row", 64'(hs_row[0]), 64'd0);
    check_val("r1_done_n", 64'(done_cyc.size()), 64'd1);
    check_val("r1_done_cyc", 64'(done_cyc[0]), 64'(hs_cyc[0] + 1));
    check_val("r1_busy_fall", 64'(bfall_cyc[0]), 64'(done_cyc[0] + 1));

    // three rows, matrix address wrap, stall on row 1, ignored start
    clear_logs();
    exp_mat2 = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001, 13'h0002, 13'h0003};
    start_job(16'd3, 32'd2, 13'h1FFE, 13'h005, t);
    wait_rn(1);
    no_of_rows = 16'd9; no_of_multiples = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; no_of_rows = '0; no_of_multiples = '0;
    check_val("r3_ignored_start_m", 64'(dp_no_of_multiples), 64'd2);
    do_row(2, 64'h111, 0);
    do_row(4, 64'h222, 5);
    do_row(6, 64'h333, 0);
    wait_idle();
    check_val("r3_rd_n", 64'(rd_cyc.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("r3_mat%0d", i), 64'(mat_q[i]), 64'(exp_mat2[i]));
      check_val($sformatf("r3_vec%0d", i), 64'(vec_q[i]), 64'(13'h005 + (i % 2)));
    end
    check_val("r3_hs_n", 64'(hs_cyc.size()), 64'd3);
    check_val("r3_data0", hs_data[0], 64'h111);
    check_val("r3_data1", hs_data[1], 64'h222);
    check_val("r3_data2", hs_data[2], 64'h333);
    for (int i = 0; i < 3; i++)
      check_val($sformatf("r3_row%0d", i), 64'(hs_row[i]), 64'(i));
    check_val("r3_stall_len", 64'(hs_cyc[1] - vrise_cyc[1]), 64'd5);
    check_val("r3_clr_n", 64'(clr_cyc.size()), 64'd3);
    check_val("r3_clr1_after_hs", 64'(clr_cyc[1]), 64'(hs_cyc[0] + 1));
    check_val("r3_clr2_after_hs", 64'(clr_cyc[2]), 64'(hs_cyc[1] + 1));
    check_val("r3_done_cyc", 64'(done_cyc[0]), 64'(hs_cyc[2] + 1));

    // zero rows
    clear_logs();
    start_job(16'd0, 32'd5, 13'h100, 13'h200, t);
    wait_idle();
    check_val("z0_done_n", 64'(done_cyc.size()), 64'd1);
    check_val("z0_done_cyc", 64'(done_cyc[0]), 64'(t + 1));
    check_val("z0_busy_fall", 64'(bfall_cyc[0]), 64'(t + 2));
    check_val("z0_no_activity", 64'(rd_cyc.size() + clr_cyc.size() + rst_cyc.size() + rn_cyc.size()), 64'd0);
    check_val("z0_dp_m", 64'(dp_no_of_multiples), 64'd5);

    // zero packages
    clear_logs();
    start_job(16'd4, 32'd0, 13'h100, 13'h200, t);
    wait_idle();
    check_val("zm_done_cyc", 64'(done_cyc[0]), 64'(t + 1));
    check_val("zm_no_activity", 64'(rd_cyc.size() + clr_cyc.size() + rst_cyc.size() + rn_cyc.size()), 64'd0);

    // reset in the middle of ISSUE
    clear_logs();
    start_job(16'd2, 32'd4, 13'h100, 13'h200, t);
    for (int i = 0; i < 40 && !mat_rd_en; i++) tick();
    check_val("ab_rd_seen", 64'(mat_rd_en), 64'd1);
    main_reset = 1'b1;
    #1;
    check_val("ab_strobes", 64'({busy, done, mat_rd_en, vec_rd_en, dp_clear, dp_reset, dp_read_now, res_valid}), 64'd0);
    check_val("ab_mat_addr", 64'(mat_rd_addr), 64'd0);
    check_val("ab_dp_m", 64'(dp_no_of_multiples), 64'd0);
    tick();
    main_reset = 1'b0;
    clear_logs();
    repeat (20) tick();
    check_val("ab_no_done", 64'(done_cyc.size() + hs_cyc.size()), 64'd0);
    start_job(16'd1, 32'd1, 13'h030, 13'h040, t);
    do_row(1, 64'h5A5A, 0);
    wait_idle();
    check_val("ab_new_mat", 64'(mat_q[0]), 64'h030);
    check_val("ab_new_vec", 64'(vec_q[0]), 64'h040);
    check_val("ab_new_data", hs_data[0], 64'h5A5A);
    check_val("ab_new_done", 64'(done_cyc.size()), 64'd1);

`ifdef DP_SCHED_TIMEOUT_EN
    // watchdog: finish never rises
    clear_logs();
    start_job(16'd2, 32'd1, 13'h000, 13'h000, t);
    wait_idle();
    check_val("wd_err", 64'(timeout_err), 64'd1);
    check_val("wd_done_n", 64'(done_cyc.size()), 64'd1);
    check_val("wd_done_cyc", 64'(done_cyc[0]), 64'(rn_cyc[0] + TMO + 1));
    check_val("wd_no_valid", 64'(vrise_cyc.size()), 64'd0);
    start_job(16'd0, 32'd1, 13'h000, 13'h000, t);
    check_val("wd_err_clear", 64'(timeout_err), 64'd0);
    wait_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "bench time limit");
  end

endmodule
